// File: rtl/mdio_phy_responder_pkg.sv
// Shared definitions for the Clause 22 MDIO responder: frame field codes, FSM state
// encoding, register-file geometry and a small OP decode helper.
`timescale 1ns/1ps
package mdio_phy_responder_pkg;

   // Frame field codes, two bits each, first-transmitted bit in [1].
   localparam logic [1:0] MdioSt    = 2'b01;
   localparam logic [1:0] MdioOpRd  = 2'b10;
   localparam logic [1:0] MdioOpWr  = 2'b01;
   localparam logic [1:0] MdioTaWr  = 2'b10;

   localparam int unsigned DataW   = 16;
   localparam int unsigned AddrW   = 5;
   localparam int unsigned NumRegs = 32;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StOp,
      StPhyad,
      StRegad,
      StTa,
      StRdData,
      StWrData
   } state_e;

   function automatic logic op_valid(input logic [1:0] op);
      return (op == MdioOpRd) || (op == MdioOpWr);
   endfunction

endpackage

// File: rtl/mdio_phy_responder_if.sv
// MDIO pad signals plus the local register-file port and commit/error indications.
//   mdc_i, mdio_i            : MDC and MDIO pad inputs (asynchronous to CLK)
//   mdio_o, mdio_oe          : MDIO pad output data and drive enable
//   lcl_wr_en/addr/wdata     : local register write port
//   lcl_rd_addr, lcl_rdata   : local register read port, 1-cycle latency
//   mdio_wr_valid/addr/data  : pulse reporting a committed MDIO write
//   frame_err                : pulse on bad OP or bad write turnaround
// The slave modport is the responder; master is the environment driving it.
`timescale 1ns/1ps
interface mdio_phy_responder_if;
   logic        mdc_i;
   logic        mdio_i;
   logic        mdio_o;
   logic        mdio_oe;
   logic        lcl_wr_en;
   logic [4:0]  lcl_addr;
   logic [15:0] lcl_wdata;
   logic [4:0]  lcl_rd_addr;
   logic [15:0] lcl_rdata;
   logic        mdio_wr_valid;
   logic [4:0]  mdio_wr_addr;
   logic [15:0] mdio_wr_data;
   logic        frame_err;

   modport slave (
      input  mdc_i, mdio_i, lcl_wr_en, lcl_addr, lcl_wdata, lcl_rd_addr,
      output mdio_o, mdio_oe, lcl_rdata, mdio_wr_valid, mdio_wr_addr, mdio_wr_data, frame_err
   );

   modport master (
      output mdc_i, mdio_i, lcl_wr_en, lcl_addr, lcl_wdata, lcl_rd_addr,
      input  mdio_o, mdio_oe, lcl_rdata, mdio_wr_valid, mdio_wr_addr, mdio_wr_data, frame_err
   );
endinterface

// File: rtl/mdio_phy_responder_sync_edge.sv
// Brings MDC and MDIO into the CLK domain and flags MDC rising edges.
//   CLK, RST  : system clock, asynchronous active-high reset
//   mdc_pin   : raw MDC input
//   mdio_pin  : raw MDIO input
//   rise      : 1-cycle pulse per detected MDC rising edge
//   mdio_bit  : MDIO sampled with the same sync depth as MDC, valid when rise=1
`timescale 1ns/1ps
module mdio_phy_responder_sync_edge (
   input  logic CLK,
   input  logic RST,
   input  logic mdc_pin,
   input  logic mdio_pin,
   output logic rise,
   output logic mdio_bit
);
   // mdc_q[2] is the extra stage used only for edge detection.
   logic [2:0] mdc_q;
   logic [1:0] mdio_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mdc_q  <= '0;
         mdio_q <= '0;
      end else begin
         mdc_q  <= {mdc_q[1:0], mdc_pin};
         mdio_q <= {mdio_q[0], mdio_pin};
      end
   end

   assign rise     = mdc_q[1] & ~mdc_q[2];
   assign mdio_bit = mdio_q[1];

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO responder (PHY side) with a 32x16 register file.
//   CLK, RST : system clock (>= 8x MDC), asynchronous active-high reset
//   bus      : slave modport carrying MDIO pads, local register port and
//              write-commit / frame-error pulses
// Frames are decoded one bit per synchronised MDC rise. Read data is driven
// from a snapshot taken at the first turnaround bit so that local writes
// during the data phase do not disturb bits already in flight.
`timescale 1ns/1ps
module mdio_phy_responder
   import mdio_phy_responder_pkg::*;
#(
   parameter logic [4:0]  PHY_ADDR = 5'd7,
   parameter int unsigned PRE_MIN  = 32,
   parameter logic [31:0] RO_MASK  = 32'h0000_0006
) (
   input logic                 CLK,
   input logic                 RST,
   mdio_phy_responder_if.slave bus
);
   localparam int unsigned PcntW = $clog2(PRE_MIN + 1);

   logic             rise;
   logic             mdio_bit;
   state_e           state_q, state_d;
   logic [PcntW-1:0] pcnt_q, pcnt_d;
   logic [4:0]       bcnt_q, bcnt_d;
   logic [1:0]       op_q, op_d;
   logic [4:0]       phyad_q, phyad_d;
   logic [4:0]       regad_q, regad_d;
   logic [15:0]      shift_q, shift_d;
   logic             o_q, o_d;
   logic             oe_q, oe_d;
   logic             err_q, err_d;
   logic             commit;
   logic             wr_valid_q;
   logic [4:0]       wr_addr_q;
   logic [15:0]      wr_data_q;
   logic [15:0]      regs_q [NumRegs];
   logic [15:0]      lcl_rdata_q;
   logic             pre_ok;

   mdio_phy_responder_sync_edge u_sync (
      .CLK      (CLK),
      .RST      (RST),
      .mdc_pin  (bus.mdc_i),
      .mdio_pin (bus.mdio_i),
      .rise     (rise),
      .mdio_bit (mdio_bit)
   );

   assign pre_ok = (pcnt_q >= PcntW'(PRE_MIN));

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; only an MDC rise can move the FSM.
   always_comb begin
      state_d = state_q;
      if (rise) begin
         unique case (state_q)
            StIdle:   if (mdio_bit == MdioSt[1] && pre_ok) state_d = StStart;
            StStart:  state_d = (mdio_bit == MdioSt[0]) ? StOp : StIdle;
            StOp:     if (bcnt_q == 5'd1) begin
                         state_d = op_valid({op_q[0], mdio_bit}) ? StPhyad : StIdle;
                      end
            StPhyad:  if (bcnt_q == 5'd4) begin
                         state_d = ({phyad_q[3:0], mdio_bit} == PHY_ADDR) ? StRegad : StIdle;
                      end
            StRegad:  if (bcnt_q == 5'd4) state_d = StTa;
            StTa:     if (op_q == MdioOpRd) begin
                         state_d = StRdData;
                      end else if (bcnt_q == 5'd0) begin
                         state_d = (mdio_bit == MdioTaWr[1]) ? StTa : StIdle;
                      end else begin
                         state_d = (mdio_bit == MdioTaWr[0]) ? StWrData : StIdle;
                      end
            // bcnt 0..15 drive D15..D0; the 17th rise releases the pad.
            StRdData: if (bcnt_q == 5'd16) state_d = StIdle;
            StWrData: if (bcnt_q == 5'd15) state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   // Datapath and output next values.
   always_comb begin
      pcnt_d  = pcnt_q;
      bcnt_d  = bcnt_q;
      op_d    = op_q;
      phyad_d = phyad_q;
      regad_d = regad_q;
      shift_d = shift_q;
      o_d     = o_q;
      oe_d    = oe_q;
      err_d   = 1'b0;
      commit  = 1'b0;
      if (rise) begin
         bcnt_d = (state_d != state_q) ? 5'd0 : bcnt_q + 5'd1;
         unique case (state_q)
            StIdle: begin
               if (!mdio_bit) begin
                  pcnt_d = '0;
               end else if (pcnt_q < PcntW'(PRE_MIN)) begin
                  pcnt_d = pcnt_q + PcntW'(1);
               end
            end
            StOp: begin
               op_d = {op_q[0], mdio_bit};
               if (bcnt_q == 5'd1 && state_d == StIdle) err_d = 1'b1;
            end
            StPhyad: phyad_d = {phyad_q[3:0], mdio_bit};
            StRegad: regad_d = {regad_q[3:0], mdio_bit};
            StTa: begin
               if (op_q == MdioOpRd) begin
                  shift_d = regs_q[regad_q];
                  oe_d    = 1'b1;
                  o_d     = 1'b0;
               end else if (state_d == StIdle) begin
                  err_d = 1'b1;
               end
            end
            StRdData: begin
               if (bcnt_q == 5'd16) begin
                  oe_d = 1'b0;
                  o_d  = 1'b0;
               end else begin
                  o_d     = shift_q[15];
                  shift_d = {shift_q[14:0], 1'b0};
               end
            end
            StWrData: begin
               shift_d = {shift_q[14:0], mdio_bit};
               if (bcnt_q == 5'd15 && !RO_MASK[regad_q]) commit = 1'b1;
            end
            default: ;
         endcase
         // Every frame end, good or bad, demands a fresh full preamble.
         if (state_q != StIdle && state_d == StIdle) pcnt_d = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pcnt_q     <= '0;
         bcnt_q     <= '0;
         op_q       <= '0;
         phyad_q    <= '0;
         regad_q    <= '0;
         shift_q    <= '0;
         o_q        <= 1'b0;
         oe_q       <= 1'b0;
         err_q      <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         pcnt_q     <= pcnt_d;
         bcnt_q     <= bcnt_d;
         op_q       <= op_d;
         phyad_q    <= phyad_d;
         regad_q    <= regad_d;
         shift_q    <= shift_d;
         o_q        <= o_d;
         oe_q       <= oe_d;
         err_q      <= err_d;
         wr_valid_q <= commit;
         if (commit) begin
            wr_addr_q <= regad_q;
            wr_data_q <= shift_d;
         end
      end
   end

   // Register file; an MDIO commit beats a local write to the same address.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
         lcl_rdata_q <= '0;
      end else begin
         if (commit) regs_q[regad_q] <= shift_d;
         if (bus.lcl_wr_en && !(commit && bus.lcl_addr == regad_q)) begin
            regs_q[bus.lcl_addr] <= bus.lcl_wdata;
         end
         lcl_rdata_q <= regs_q[bus.lcl_rd_addr];
      end
   end

   // Outputs.
   always_comb begin
      bus.mdio_o        = o_q;
      bus.mdio_oe       = oe_q;
      bus.lcl_rdata     = lcl_rdata_q;
      bus.mdio_wr_valid = wr_valid_q;
      bus.mdio_wr_addr  = wr_addr_q;
      bus.mdio_wr_data  = wr_data_q;
      bus.frame_err     = err_q;
   end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: a table of whole MDIO frames with
// hand-computed outcomes, then hand-written sequences for write collisions,
// local writes during read-out and reset in the middle of a read.
`timescale 1ns/1ps
module tb_mdio_phy_responder;

   localparam int HalfNs = 200;  // MDC = 2.5 MHz
   localparam logic [1:0] Rd = 2'b10;
   localparam logic [1:0] Wr = 2'b01;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   mdio_phy_responder_if bus ();

   mdio_phy_responder #(
      .PHY_ADDR (5'd7),
      .PRE_MIN  (32),
      .RO_MASK  (32'h0000_0006)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #4 CLK = ~CLK;  // 125 MHz

   // Pulse/level monitor, sampled on the inactive edge.
   int          wr_cnt = 0;
   int          err_cnt = 0;
   int          oe_cnt = 0;
   logic [4:0]  last_wa = '0;
   logic [15:0] last_wd = '0;

   always @(negedge CLK) begin
      if (bus.mdio_wr_valid) begin
         wr_cnt++;
         last_wa = bus.mdio_wr_addr;
         last_wd = bus.mdio_wr_data;
      end
      if (bus.frame_err) err_cnt++;
      if (bus.mdio_oe) oe_cnt++;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One MDC period: drive MDIO while MDC low, sample pad just before the rise.
   task automatic mdc_bit(input logic b, output logic s_o, output logic s_oe);
      bus.mdio_i = b;
      #(HalfNs);
      s_o  = bus.mdio_o;
      s_oe = bus.mdio_oe;
      bus.mdc_i = 1'b1;
      #(HalfNs);
      bus.mdc_i = 1'b0;
   endtask

   task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] regad, input logic [1:0] ta,
                            input logic [15:0] wdata, output logic [15:0] rd,
                            output logic ta2_o);
      logic [13:0] hdr;
      logic        s_o, s_oe;
      hdr   = {2'b01, op, phy, regad};
      rd    = '0;
      ta2_o = 1'b1;
      for (int i = 0; i < pre; i++) mdc_bit(1'b1, s_o, s_oe);
      for (int i = 13; i >= 0; i--) mdc_bit(hdr[i], s_o, s_oe);
      if (op == Rd) begin
         mdc_bit(1'b1, s_o, s_oe);
         mdc_bit(1'b1, ta2_o, s_oe);
         for (int i = 0; i < 16; i++) begin
            mdc_bit(1'b1, s_o, s_oe);
            rd = {rd[14:0], s_o};
         end
      end else begin
         mdc_bit(ta[1], s_o, s_oe);
         mdc_bit(ta[0], s_o, s_oe);
         for (int i = 15; i >= 0; i--) mdc_bit(wdata[i], s_o, s_oe);
      end
   endtask

   task automatic lcl_write(input logic [4:0] a, input logic [15:0] d);
      @(negedge CLK);
      bus.lcl_wr_en = 1'b1;
      bus.lcl_addr  = a;
      bus.lcl_wdata = d;
      @(negedge CLK);
      bus.lcl_wr_en = 1'b0;
   endtask

   task automatic lcl_read(input logic [4:0] a, output logic [15:0] d);
      @(negedge CLK);
      bus.lcl_rd_addr = a;
      @(negedge CLK);
      @(negedge CLK);
      d = bus.lcl_rdata;
   endtask

   typedef struct {
      int          pre;
      logic [1:0]  op;
      logic [4:0]  phy;
      logic [4:0]  regad;
      logic [1:0]  ta;
      logic [15:0] wdata;
      logic        pre_wr;   // local write of pre_val to regad before the frame
      logic [15:0] pre_val;
      logic        exp_ans;  // responder drives the pad during the frame
      logic [15:0] exp_rd;
      int          exp_wr;   // mdio_wr_valid pulses in the frame
      int          exp_err;  // frame_err pulses in the frame
      logic [4:0]  exp_wa;
      logic [15:0] exp_wd;
      logic        chk_lcl;  // check lcl_rdata of regad after the frame
      logic [15:0] exp_lcl;
   } vec_t;

   vec_t        tbl [11];
   logic [15:0] rd, lv;
   logic        ta2, found;
   int          w0, e0, o0;

   initial begin
      tbl[0]  = '{32, Rd,    5'd7, 5'd2, 2'b11, 16'h0000, 1'b1, 16'h0141,
                  1'b1, 16'h0141, 0, 0, 5'd0, 16'h0000, 1'b1, 16'h0141};
      tbl[1]  = '{32, Wr,    5'd7, 5'd0, 2'b10, 16'h1140, 1'b0, 16'h0000,
                  1'b0, 16'h0000, 1, 0, 5'd0, 16'h1140, 1'b1, 16'h1140};
      tbl[2]  = '{32, Rd,    5'd7, 5'd0, 2'b11, 16'h0000, 1'b0, 16'h0000,
                  1'b1, 16'h1140, 0, 0, 5'd0, 16'h0000, 1'b1, 16'h1140};
      tbl[3]  = '{32, Wr,    5'd7, 5'd1, 2'b10, 16'hFFFF, 1'b0, 16'h0000,
                  1'b0, 16'h0000, 0, 0, 5'd0, 16'h0000, 1'b1, 16'h0000};
      tbl[4]  = '{32, Rd,    5'd7, 5'd1, 2'b11, 16'h0000, 1'b0, 16'h0000,
                  1'b1, 16'h0000, 0, 0, 5'd0, 16'h0000, 1'b0, 16'h0000};
      tbl[5]  = '{32, Rd,    5'd3, 5'd0, 2'b11, 16'h0000, 1'b0, 16'h0000,
                  1'b0, 16'h0000, 0, 0, 5'd0, 16'h0000, 1'b0, 16'h0000};
      tbl[6]  = '{32, Rd,    5'd7, 5'd0, 2'b11, 16'h0000, 1'b0, 16'h0000,
                  1'b1, 16'h1140, 0, 0, 5'd0, 16'h0000, 1'b0, 16'h0000};
      tbl[7]  = '{31, Rd,    5'd7, 5'd0, 2'b11, 16'h0000, 1'b0, 16'h0000,
                  1'b0, 16'h0000, 0, 0, 5'd0, 16'h0000, 1'b0, 16'h0000};
      tbl[8]  = '{32, 2'b11, 5'd7, 5'd3, 2'b10, 16'h1234, 1'b0, 16'h0000,
                  1'b0, 16'h0000, 0, 1, 5'd0, 16'h0000, 1'b0, 16'h0000};
      tbl[9]  = '{32, Wr,    5'd7, 5'd3, 2'b00, 16'h1234, 1'b0, 16'h0000,
                  1'b0, 16'h0000, 0, 1, 5'd0, 16'h0000, 1'b1, 16'h0000};
      tbl[10] = '{32, Rd,    5'd7, 5'd3, 2'b11, 16'h0000, 1'b0, 16'h0000,
                  1'b1, 16'h0000, 0, 0, 5'd0, 16'h0000, 1'b0, 16'h0000};

      bus.mdc_i       = 1'b0;
      bus.mdio_i      = 1'b1;
      bus.lcl_wr_en   = 1'b0;
      bus.lcl_addr    = '0;
      bus.lcl_wdata   = '0;
      bus.lcl_rd_addr = '0;

      #20;
      chk("rst_oe", bus.mdio_oe, 1'b0);
      chk("rst_o", bus.mdio_o, 1'b0);
      chk("rst_wr_valid", bus.mdio_wr_valid, 1'b0);
      chk("rst_frame_err", bus.frame_err, 1'b0);
      chk("rst_lcl_rdata", bus.lcl_rdata, 16'h0000);
      @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < 11; i++) begin
         if (tbl[i].pre_wr) lcl_write(tbl[i].regad, tbl[i].pre_val);
         w0 = wr_cnt;
         e0 = err_cnt;
         o0 = oe_cnt;
         run_frame(tbl[i].pre, tbl[i].op, tbl[i].phy, tbl[i].regad, tbl[i].ta,
                   tbl[i].wdata, rd, ta2);
         $display("vector %0d", i);
         chk("answered", 32'((oe_cnt - o0) > 0), 32'(tbl[i].exp_ans));
         if (tbl[i].exp_ans) begin
            chk("rd_data", rd, tbl[i].exp_rd);
            chk("ta2_zero", ta2, 1'b0);
         end
         chk("wr_pulses", wr_cnt - w0, tbl[i].exp_wr);
         chk("err_pulses", err_cnt - e0, tbl[i].exp_err);
         if (tbl[i].exp_wr > 0) begin
            chk("wr_addr", last_wa, tbl[i].exp_wa);
            chk("wr_data", last_wd, tbl[i].exp_wd);
         end
         chk("oe_released", bus.mdio_oe, 1'b0);
         if (tbl[i].chk_lcl) begin
            lcl_read(tbl[i].regad, lv);
            chk("lcl_rdata", lv, tbl[i].exp_lcl);
         end
      end

      // MDIO commit and local write to reg4 in the same cycle: MDIO value stays.
      w0 = wr_cnt;
      fork
         run_frame(32, Wr, 5'd7, 5'd4, 2'b10, 16'h5A5A, rd, ta2);
         begin
            bus.lcl_wr_en = 1'b1;
            bus.lcl_addr  = 5'd4;
            bus.lcl_wdata = 16'hBEEF;
            found = 1'b0;
            for (int c = 0; c < 6000 && !found; c++) begin
               @(negedge CLK);
               if (bus.mdio_wr_valid) found = 1'b1;
            end
            bus.lcl_wr_en = 1'b0;
            chk("coinc_commit_seen", found, 1'b1);
         end
      join
      chk("coinc_wr_pulses", wr_cnt - w0, 1);
      lcl_read(5'd4, lv);
      chk("coinc_same_addr", lv, 16'h5A5A);

      // Same cycle, different addresses: both land.
      fork
         run_frame(32, Wr, 5'd7, 5'd6, 2'b10, 16'hCAFE, rd, ta2);
         begin
            bus.lcl_wr_en = 1'b1;
            bus.lcl_addr  = 5'd5;
            bus.lcl_wdata = 16'hBEEF;
            found = 1'b0;
            for (int c = 0; c < 6000 && !found; c++) begin
               @(negedge CLK);
               if (bus.mdio_wr_valid) found = 1'b1;
            end
            bus.lcl_wr_en = 1'b0;
            chk("diff_commit_seen", found, 1'b1);
         end
      join
      lcl_read(5'd5, lv);
      chk("diff_lcl_reg5", lv, 16'hBEEF);
      lcl_read(5'd6, lv);
      chk("diff_mdio_reg6", lv, 16'hCAFE);

      // Local write to reg2 while reg2 is being shifted out: old value on the wire.
      fork
         run_frame(32, Rd, 5'd7, 5'd2, 2'b11, 16'h0000, rd, ta2);
         begin
            found = 1'b0;
            for (int c = 0; c < 6000 && !found; c++) begin
               @(negedge CLK);
               if (bus.mdio_oe) found = 1'b1;
            end
            chk("inflight_oe_seen", found, 1'b1);
            repeat (100) @(negedge CLK);
            lcl_write(5'd2, 16'hDEAD);
         end
      join
      chk("inflight_rd_data", rd, 16'h0141);
      lcl_read(5'd2, lv);
      chk("inflight_lcl_new", lv, 16'hDEAD);

      // Reset in the middle of a read, around data bit 8.
      fork
         run_frame(32, Rd, 5'd7, 5'd2, 2'b11, 16'h0000, rd, ta2);
         begin
            found = 1'b0;
            for (int c = 0; c < 6000 && !found; c++) begin
               @(negedge CLK);
               if (bus.mdio_oe) found = 1'b1;
            end
            chk("rstmid_oe_seen", found, 1'b1);
            repeat (9 * 50) @(negedge CLK);
            RST = 1'b1;
            #1;
            chk("rstmid_oe_low", bus.mdio_oe, 1'b0);
            chk("rstmid_o_low", bus.mdio_o, 1'b0);
            @(negedge CLK);
            @(negedge CLK);
            RST = 1'b0;
         end
      join
      lcl_read(5'd2, lv);
      chk("rstmid_reg2_cleared", lv, 16'h0000);
      o0 = oe_cnt;
      run_frame(32, Rd, 5'd7, 5'd0, 2'b11, 16'h0000, rd, ta2);
      chk("post_rst_answered", 32'((oe_cnt - o0) > 0), 32'(1));
      chk("post_rst_rd_data", rd, 16'h0000);
      chk("post_rst_ta2", ta2, 1'b0);
      chk("post_rst_oe_released", bus.mdio_oe, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
